// File: rtl/addsub_result_stage.sv
// Result stage of the VPU add/sub path: rebuilds the signed sum from the adder outputs, converts it
// to 33-bit sign-magnitude with saturation, and counts overflows, behind a two-stage valid/ready pipe.
module addsub_result_stage #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_sum,
  input  logic             in_cout,
  input  logic             in_a_neg,
  input  logic             in_b_neg,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32:0]      out_result,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);

  logic             s1_valid_q, s1_valid_d;
  logic             s1_neg_q, s1_neg_d;
  logic [32:0]      s1_mag_q, s1_mag_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             out_valid_q, out_valid_d;
  logic [32:0]      out_result_q, out_result_d;
  logic             out_ovf_q, out_ovf_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  logic        s2_adv, s1_adv;
  logic [1:0]  top;
  logic [33:0] s_full, s_abs;
  logic        cnt_inc;

  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Sign-extend both operands to 34 bits and fold the adder carry into the top two bits.
  assign top    = {in_a_neg, in_a_neg} + {in_b_neg, in_b_neg} + {1'b0, in_cout};
  assign s_full = {top, in_sum};
  assign s_abs  = s_full[33] ? (~s_full + 34'd1) : s_full;

  assign cnt_inc = s1_adv & in_valid & s_abs[32];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_neg_d   = s1_neg_q;
    s1_mag_d   = s1_mag_q;
    s1_tag_d   = s1_tag_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_neg_d = s_full[33];
        s1_mag_d = s_abs[32:0];
        s1_tag_d = in_tag;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    out_tag_d    = out_tag_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        // A zero magnitude always carries a positive sign.
        out_result_d = {s1_neg_q & (|s1_mag_q), s1_mag_q[32] ? 32'hFFFF_FFFF : s1_mag_q[31:0]};
        out_ovf_d    = s1_mag_q[32];
        out_tag_d    = s1_tag_q;
      end
    end
  end

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr) begin
      ovf_count_d = {{(CNT_W-1){1'b0}}, cnt_inc};
    end else if (cnt_inc && !(&ovf_count_q)) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_neg_q     <= 1'b0;
      s1_mag_q     <= '0;
      s1_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_tag_q    <= '0;
      ovf_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_neg_q     <= s1_neg_d;
      s1_mag_q     <= s1_mag_d;
      s1_tag_q     <= s1_tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
      out_tag_q    <= out_tag_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;
  assign out_tag    = out_tag_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Bench for addsub_result_stage: directed cases plus randomized signed operands scored against an
// integer-arithmetic reference, with a queue tracking in-flight results and a saturating count model.
module tb_addsub_result_stage;

  localparam int unsigned TagW = 4;
  localparam int unsigned CntW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_sum;
  logic            in_cout;
  logic            in_a_neg;
  logic            in_b_neg;
  logic [TagW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [32:0]     out_result;
  logic            out_ovf;
  logic [TagW-1:0] out_tag;
  logic [CntW-1:0] ovf_count;
  logic            ovf_clr;

  addsub_result_stage #(
    .TAG_W(TagW),
    .CNT_W(CntW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_a_neg  (in_a_neg),
    .in_b_neg  (in_b_neg),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag),
    .ovf_count (ovf_count),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [32:0]     res;
    logic            ovf;
    logic [TagW-1:0] tag;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  exp_t q[$];
  int unsigned model_cnt = 0;
  logic [32:0] exp_res;
  logic        exp_ovf;
  int rdy_mode = 0;
  int pat_idx  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer: 0 always ready, 1 pattern 1,0,0, 2 random, 3 stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (pat_idx == 0);
        pat_idx   = (pat_idx + 1) % 3;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard: q holds every result currently inside the pipeline, oldest first.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      model_cnt = 0;
    end else begin
      check_eq("ovf_count", 64'(ovf_count), 64'(model_cnt));
      if (out_valid) begin
        if (q.size() == 0) begin
          check_eq("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check_eq("out_result", 64'(out_result), 64'(q[0].res));
          check_eq("out_ovf", 64'(out_ovf), 64'(q[0].ovf));
          check_eq("out_tag", 64'(out_tag), 64'(q[0].tag));
        end
      end
      if (q.size() == 2) check_eq("out_valid_full", 64'(out_valid), 64'd1);
      check_eq("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        q.push_back('{res: exp_res, ovf: exp_ovf, tag: in_tag});
        if (ovf_clr) model_cnt = exp_ovf ? 1 : 0;
        else if (exp_ovf && model_cnt < (1 << CntW) - 1) model_cnt++;
      end else if (ovf_clr) begin
        model_cnt = 0;
      end
    end
  end

  task automatic send_raw(input logic [31:0] s, input logic c, input logic an, input logic bn,
                          input logic [TagW-1:0] tg, input logic [32:0] er, input logic eo);
    int guard = 0;
    in_valid = 1'b1;
    in_sum   = s;
    in_cout  = c;
    in_a_neg = an;
    in_b_neg = bn;
    in_tag   = tg;
    exp_res  = er;
    exp_ovf  = eo;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference: operands as plain signed integers, result from ordinary arithmetic.
  task automatic send_ops(input longint a, input longint b, input logic [TagW-1:0] tg);
    logic [32:0]    lo;
    longint         r;
    longint         mg;
    logic [63:0]    mgv;
    logic           ovf;
    logic [32:0]    res;
    lo  = {1'b0, a[31:0]} + {1'b0, b[31:0]};
    r   = a + b;
    mg  = (r < 0) ? -r : r;
    mgv = mg;
    ovf = (mg >= 64'sh1_0000_0000);
    res = {(r < 0), ovf ? 32'hFFFF_FFFF : mgv[31:0]};
    send_raw(lo[31:0], lo[32], (a < 0), (b < 0), tg, res, ovf);
  endtask

  function automatic longint rand_op();
    longint m;
    if ($urandom_range(0, 3) == 0) m = longint'($urandom_range(0, 3));
    else m = longint'($urandom);
    return ($urandom_range(0, 1) == 1) ? -m : m;
  endfunction

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; in_a_neg = 1'b0;
    in_b_neg = 1'b0; in_tag = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    exp_res = '0; exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_result", 64'(out_result), 64'd0);
    check_eq("rst_out_ovf", 64'(out_ovf), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_ovf_count", 64'(ovf_count), 64'd0);
    @(posedge clk);
    #1;

    // Spec examples with literal expectations; latency checked on the first.
    send_raw(32'h0000_0002, 1'b1, 1'b0, 1'b1, 4'd1, 33'h0_0000_0002, 1'b0);
    @(negedge clk);
    check_eq("lat_s1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq("lat_s2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    send_raw(32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1, 4'd2, 33'h1_0000_0002, 1'b0);
    send_raw(32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd3, 33'h0_FFFF_FFFF, 1'b1);
    send_raw(32'h0000_0000, 1'b1, 1'b1, 1'b0, 4'd4, 33'h0_0000_0000, 1'b0);
    drain();
    check_eq("ovf_count_one", 64'(ovf_count), 64'd1);

    // Tagged stream under a 1,0,0 consumer pattern.
    rdy_mode = 1;
    pat_idx  = 0;
    for (int i = 0; i < 8; i++) send_ops(rand_op(), rand_op(), 4'(i));
    drain();

    // Saturation of the overflow counter, then clear with and without an increment.
    rdy_mode = 0;
    for (int i = 0; i < (1 << CntW) + 3; i++) send_ops(64'sh0_FFFF_FFFF, 64'sd1, 4'(i));
    drain();
    check_eq("ovf_count_sat", 64'(ovf_count), 64'((1 << CntW) - 1));
    ovf_clr = 1'b1;
    send_ops(-64'sh0_FFFF_FFFF, -64'sd7, 4'd9);
    ovf_clr = 1'b0;
    @(negedge clk);
    check_eq("ovf_clr_with_inc", 64'(ovf_count), 64'd1);
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    check_eq("ovf_clr_alone", 64'(ovf_count), 64'd0);
    drain();

    // Reset with both stages full.
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send_ops(64'sd10, 64'sd20, 4'd5);
    send_ops(-64'sd10, 64'sd3, 4'd6);
    @(negedge clk);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_mid_in_ready", 64'(in_ready), 64'd1);
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;

    // Random traffic under a random consumer.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send_ops(rand_op(), rand_op(), 4'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
